// File: rtl/mc_sample_sequencer.sv
// Monte Carlo sample sequencer: walks the weight/confidence memory once per
// sample, feeding base, confidence and an LFSR mask to the perturbation datapath.
module mc_sample_sequencer #(
    parameter int          WORD_SIZE   = 8,
    parameter int          ADDR_W      = 4,
    parameter int          NUM_WEIGHTS = 16,
    parameter int          SAMPLE_W    = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SAMPLE_W-1:0]  num_samples,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0] mem_base,
    input  logic [WORD_SIZE-1:0] mem_conf,
    output logic [WORD_SIZE-1:0] pert_base,
    output logic [WORD_SIZE-1:0] pert_conf,
    output logic [WORD_SIZE-1:0] pert_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [SAMPLE_W-1:0]  out_sample
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [SAMPLE_W-1:0]  count_q, count_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_SIZE-1:0] base_q, base_d;
    logic [WORD_SIZE-1:0] conf_q, conf_d;
    logic [15:0]          lfsr_q, lfsr_d;

    logic last_addr;
    logic last_sample;

    assign last_addr   = (addr_q == ADDR_W'(NUM_WEIGHTS - 1));
    assign last_sample = (sample_q == count_q - SAMPLE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            sample_q <= '0;
            addr_q   <= '0;
            base_q   <= '0;
            conf_q   <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            conf_q   <= conf_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sample_d = sample_q;
        addr_d   = addr_q;
        base_d   = base_q;
        conf_d   = conf_q;
        lfsr_d   = lfsr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_samples != '0) begin
                        count_d  = num_samples;
                        addr_d   = '0;
                        sample_d = '0;
                        state_d  = S_READ;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                base_d  = mem_base;
                conf_d  = mem_conf;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // Everything holds while the consumer stalls.
                if (out_ready) begin
                    lfsr_d = {lfsr_q[14:0],
                              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    if (last_addr) begin
                        addr_d   = '0;
                        sample_d = sample_q + SAMPLE_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    state_d = (last_addr && last_sample) ? S_FINISH : S_READ;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_READ) || (state_q == S_WAIT) ||
                        (state_q == S_PRESENT);
    assign done       = (state_q == S_FINISH);
    assign mem_rd_en  = (state_q == S_READ);
    assign mem_addr   = addr_q;
    assign out_valid  = (state_q == S_PRESENT);
    assign out_addr   = addr_q;
    assign out_sample = sample_q;
    assign pert_base  = base_q;
    assign pert_conf  = conf_q;
    assign pert_mask  = lfsr_q[WORD_SIZE-1:0];

endmodule

// File: tb/tb_mc_sample_sequencer.sv
// Directed/randomized bench for mc_sample_sequencer against a queue-based
// model of the sample-major output order and the LFSR mask stream.
module tb_mc_sample_sequencer;

    localparam int NW = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_samples = '0;
    logic       busy, done, mem_rd_en, out_valid;
    logic [3:0] mem_addr, out_addr;
    logic [7:0] mem_base = '0, mem_conf = '0;
    logic [7:0] pert_base, pert_conf, pert_mask, out_sample;
    logic       out_ready = 1'b0;

    mc_sample_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_base(mem_base), .mem_conf(mem_conf), .pert_base(pert_base),
        .pert_conf(pert_conf), .pert_mask(pert_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_sample(out_sample)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_b [NW];
    logic [7:0] mem_c [NW];

    // One-cycle read latency memory.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_base <= mem_b[mem_addr];
            mem_conf <= mem_c[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_pert_base", 32'(pert_base), 32'd0);
        chk("rst_pert_conf", 32'(pert_conf), 32'd0);
        chk("rst_pert_mask", 32'(pert_mask), 32'hE1);
    endtask

    // mode 0: out_ready high; mode 1: random out_ready.
    task automatic do_run(input int ns, input int mode, input int stall_addr,
                          input int restart_cyc, input int abort_addr,
                          input bit chk_first);
        int q_s[$];
        int q_a[$];
        int rd_cnt = 0;
        int hs = 0;
        int done_cyc = -1;
        int stall_left = 0;
        bit stalled_once = 1'b0;
        logic pv, pr;
        for (int s = 0; s < ns; s++)
            for (int a = 0; a < NW; a++) begin
                q_s.push_back(s);
                q_a.push_back(a);
            end
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = 8'(ns);
        @(posedge clk); #1;
        start = 1'b0;
        num_samples = 8'($urandom);
        for (int cyc = 1; cyc <= 48 * ns + 400; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("valid_at_done", 32'(out_valid), 32'd0);
                break;
            end
            chk("busy", 32'(busy), 32'd1);
            if (mem_rd_en) begin
                rd_cnt++;
                if (q_a.size() > 0)
                    chk("mem_addr", 32'(mem_addr), 32'(q_a[0]));
            end
            pv = out_valid;
            if (out_valid) begin
                if (q_a.size() == 0) begin
                    chk("extra_output", 32'd1, 32'd0);
                end else begin
                    chk("out_addr", 32'(out_addr), 32'(q_a[0]));
                    chk("out_sample", 32'(out_sample), 32'(q_s[0]));
                    chk("pert_base", 32'(pert_base), 32'(mem_b[q_a[0]]));
                    chk("pert_conf", 32'(pert_conf), 32'(mem_c[q_a[0]]));
                    chk("pert_mask", 32'(pert_mask), 32'(lfsr_m[7:0]));
                    if (chk_first && hs < 2)
                        chk("mask_first", 32'(pert_mask),
                            (hs == 0) ? 32'hE1 : 32'hC3);
                end
                if (abort_addr >= 0 && int'(out_addr) == abort_addr) begin
                    rst_n = 1'b0;
                    out_ready = 1'b0;
                    start = 1'b0;
                    #1;
                    check_reset();
                    lfsr_m = 16'hACE1;
                    @(posedge clk); #1;
                    check_reset();
                    rst_n = 1'b1;
                    return;
                end
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (pv && stall_addr >= 0 && !stalled_once &&
                         int'(out_addr) == stall_addr) begin
                stalled_once = 1'b1;
                stall_left = 4;
                out_ready = 1'b0;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            end
            if (cyc == restart_cyc) begin
                start = 1'b1;
                num_samples = 8'd5;
            end else begin
                start = 1'b0;
            end
            pr = out_ready;
            @(posedge clk); #1;
            if (pv && pr && q_a.size() > 0) begin
                hs++;
                void'(q_a.pop_front());
                void'(q_s.pop_front());
                lfsr_m = lfsr_next(lfsr_m);
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", 32'(done_cyc > 0), 32'd1);
        chk("read_count", 32'(rd_cnt), 32'(ns * NW));
        chk("handshakes", 32'(hs), 32'(ns * NW));
        if (mode == 0 && stall_addr < 0)
            chk("done_cycle", 32'(done_cyc), 32'(3 * ns * NW + 1));
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            mem_b[i] = 8'h0F;
            mem_c[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset();

        do_run(2, 0, -1, -1, -1, 1'b1);

        for (int i = 0; i < NW; i++) begin
            mem_b[i] = 8'($urandom);
            mem_c[i] = 8'($urandom);
        end
        do_run(2, 0, 3, -1, -1, 1'b0);
        do_run(0, 0, -1, -1, -1, 1'b0);
        do_run(2, 0, -1, 10, -1, 1'b0);
        do_run(3, 1, -1, 20, -1, 1'b0);
        do_run(2, 0, -1, -1, 7, 1'b0);
        do_run(1, 0, -1, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_sample_sequencer.md
Name: mc_sample_sequencer

Overview:
- Sequences Monte Carlo weight sampling through the combinational bit-wise weight perturbation datapath.
- For each of `num_samples` passes:
  - walks all NUM_WEIGHTS addresses of the weight/confidence memory;
  - supplies base weight, confidence and a fresh LFSR random mask to the perturbation datapath;
  - presents each perturbed-weight slot to a downstream consumer with a valid/ready handshake.
- Sits between the weight/confidence SRAM and the in-memory MAC array.

Parameters:
- WORD_SIZE, 8, width of weight, confidence and mask words.
- ADDR_W, 4, memory address width.
- NUM_WEIGHTS, 16, weights per pass; must be ≤ 2^ADDR_W and ≥ 1.
- SAMPLE_W, 8, width of sample count and index.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled only in IDLE.
- num_samples  in  SAMPLE_W  passes per run; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_base  in  WORD_SIZE  base weight; valid 1 cycle after mem_rd_en.
- mem_conf  in  WORD_SIZE  confidence; valid 1 cycle after mem_rd_en.
- pert_base  out  WORD_SIZE  registered base weight to datapath.
- pert_conf  out  WORD_SIZE  registered confidence to datapath.
- pert_mask  out  WORD_SIZE  random mask to datapath = lfsr[WORD_SIZE-1:0].
- out_valid  out  1  datapath output valid for consumer.
- out_ready  in  1  consumer accepts.
- out_addr  out  ADDR_W  weight index of current output.
- out_sample  out  SAMPLE_W  sample index of current output.

Behaviour:
- Reset values (async, all outputs and state):
  - state=IDLE; busy, done, mem_rd_en, out_valid = 0.
  - mem_addr, out_addr, out_sample, pert_base, pert_conf = 0.
  - lfsr=LFSR_SEED, so pert_mask=LFSR_SEED[WORD_SIZE-1:0].
- FSM states: IDLE, READ, WAIT, PRESENT, FINISH.
  - IDLE:
    - start=1 with num_samples≠0: latch count; addr=0, sample=0; go READ.
    - start=1 with num_samples=0: go FINISH with no memory reads.
    - start=0: remain IDLE.
  - READ: mem_rd_en=1 with mem_addr=addr for exactly one cycle; go WAIT.
  - WAIT: capture mem_base→pert_base and mem_conf→pert_conf; go PRESENT.
  - PRESENT:
    - out_valid=1; out_addr and out_sample hold the indices of the captured word.
    - Handshake occurs when out_valid & out_ready.
    - While stalled (out_ready=0), all outputs, including pert_*, hold stable.
    - On handshake:
      - LFSR advances once.
      - If addr=NUM_WEIGHTS-1: addr←0 and sample++.
      - Otherwise: addr++.
      - If the handshake was on the last word (addr=NUM_WEIGHTS-1 and sample=count-1), go FINISH; otherwise go READ.
  - FINISH: done=1 for one cycle, busy=0; go IDLE.
- busy is 1 in READ, WAIT and PRESENT; 0 in IDLE and FINISH.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Update: lfsr←{lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances only on output handshake.
  - Not reseeded by start, so successive runs continue the sequence.
- Ordering: sample-major; address 0..NUM_WEIGHTS-1 per sample.
- Throughput: 3 cycles per output with out_ready tied high.
- Latency:
  - start sampled at edge T → first out_valid at T+3 (READ in T+1, WAIT in T+2, PRESENT in T+3).
  - Run of N outputs with out_ready=1 → done in cycle T+3N+1.
- start while busy: ignored; num_samples is not re-latched.
- Reset mid-run: immediate return to IDLE with all reset values; any partially presented output is discarded.
- Index widths: counters wrap naturally; no overflow is possible because sample < count ≤ 2^SAMPLE_W-1.

Test Plan:
1. Reset → check all outputs at reset values; pert_mask=8'hE1.
2. num_samples=2, out_ready=1, start pulse at T:
   - 32 handshakes; out_addr 0..15 twice; out_sample 0 then 1;
   - mem_rd_en exactly 32 times;
   - done pulse in cycle T+97; busy high T+1..T+96.
3. LFSR check, using a memory model returning base=8'h0F, conf=8'h00:
   - first pert_mask=8'hE1, second=8'hC3 (lfsr 16'h59C3);
   - reference-model perturbed outputs match.
4. Back-pressure: out_ready low for 5 cycles on word 3 → out_valid held; pert_*, out_addr=3 and pert_mask stable; LFSR does not advance; run completes with 32 outputs.
5. num_samples=0 → no mem_rd_en, no out_valid, done pulse at T+1. Separately, start re-asserted mid-run → ignored, output count unchanged.
6. rst_n low during PRESENT of word 7 → immediate IDLE and reset values. Subsequent start with num_samples=1 → 16 clean outputs starting at addr 0, mask restarting from 8'hE1.
